// File: rtl/axi_ram_arb_pkg.sv
// Shared constants for the axi_ram read-channel arbiter: FSM encoding, fixed AR
// sideband values and grant index width helper.
package axi_ram_arb_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_ADDR = 2'd1;
    localparam logic [1:0] ARB_DATA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_ADDR = ARB_ADDR,
        ST_DATA = ARB_DATA
    } arb_state_e;

    localparam logic [3:0] ARB_ARCACHE = 4'b0011;
    localparam logic [2:0] ARB_ARPROT  = 3'b000;

    function automatic int arb_grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_ram_rd_arbiter_rr_select.sv
// Combinational winner picker. Round-robin from last_grant+1 by default;
// AXI_RD_ARB_FIXED_PRIO_EN turns it into a lowest-index-wins priority encoder.
module rr_select
    import axi_ram_arb_pkg::*;
#(
    parameter int S_COUNT = 2,
    parameter int GRANT_W = arb_grant_w(S_COUNT)
) (
    input  logic [S_COUNT-1:0] i_req,
    input  logic [GRANT_W-1:0] i_last_grant,
    output logic [GRANT_W-1:0] o_grant,
    output logic               o_any_req
);

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = ^i_last_grant;

    // Lowest-index requester wins
    always_comb begin
        logic found;
        o_grant   = '0;
        found     = 1'b0;
        o_any_req = |i_req;
        for (int k = 0; k < S_COUNT; k++) begin
            if (!found && i_req[GRANT_W'(k)]) begin
                o_grant = GRANT_W'(k);
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    end
`else
    // Scan upward from the slot after the previous winner, wrapping at S_COUNT
    always_comb begin
        logic               found;
        logic [GRANT_W-1:0] idx;
        o_grant   = '0;
        found     = 1'b0;
        idx       = '0;
        o_any_req = |i_req;
        for (int k = 1; k <= S_COUNT; k++) begin
            idx = GRANT_W'((int'(i_last_grant) + k) % S_COUNT);
            if (!found && i_req[idx]) begin
                o_grant = idx;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    end
`endif

endmodule

// File: rtl/axi_ram_rd_arbiter.sv
// Shares one axi_ram AR/R read port between S_COUNT masters, one burst at a time.
// Build option: AXI_RD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module axi_ram_rd_arbiter
    import axi_ram_arb_pkg::*;
#(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [S_COUNT*ID_WIDTH-1:0]    s_axi_arid,
    input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic [S_COUNT*8-1:0]           s_axi_arlen,
    input  logic [S_COUNT*3-1:0]           s_axi_arsize,
    input  logic [S_COUNT*2-1:0]           s_axi_arburst,
    input  logic [S_COUNT-1:0]             s_axi_arvalid,
    output logic [S_COUNT-1:0]             s_axi_arready,
    output logic [S_COUNT*ID_WIDTH-1:0]    s_axi_rid,
    output logic [S_COUNT*DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [S_COUNT*2-1:0]           s_axi_rresp,
    output logic [S_COUNT-1:0]             s_axi_rlast,
    output logic [S_COUNT-1:0]             s_axi_rvalid,
    input  logic [S_COUNT-1:0]             s_axi_rready,
    output logic [ID_WIDTH-1:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic                           m_axi_arlock,
    output logic [3:0]                     m_axi_arcache,
    output logic [2:0]                     m_axi_arprot,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [ID_WIDTH-1:0]            m_axi_rid,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rlast,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready
);

    localparam int GRANT_W = arb_grant_w(S_COUNT);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic [GRANT_W-1:0]  r_grant;
    logic [GRANT_W-1:0]  r_last_grant;
    logic [GRANT_W-1:0]  w_sel_grant;
    logic                w_any_req;
    logic                w_grant_load;
    logic                w_burst_done;

    logic [ID_WIDTH-1:0]   w_arid    [S_COUNT];
    logic [ADDR_WIDTH-1:0] w_araddr  [S_COUNT];
    logic [7:0]            w_arlen   [S_COUNT];
    logic [2:0]            w_arsize  [S_COUNT];
    logic [1:0]            w_arburst [S_COUNT];

    for (genvar k = 0; k < S_COUNT; k++) begin : g_unpack
        assign w_arid[k]    = s_axi_arid[k*ID_WIDTH +: ID_WIDTH];
        assign w_araddr[k]  = s_axi_araddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_arlen[k]   = s_axi_arlen[k*8 +: 8];
        assign w_arsize[k]  = s_axi_arsize[k*3 +: 3];
        assign w_arburst[k] = s_axi_arburst[k*2 +: 2];
    end

    rr_select #(
        .S_COUNT (S_COUNT),
        .GRANT_W (GRANT_W)
    ) u_rr_select (
        .i_req        (s_axi_arvalid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_sel_grant),
        .o_any_req    (w_any_req)
    );

    // AR payload follows the grant with no pipelining; R payload fans out to every slice
    assign m_axi_arid    = w_arid[r_grant];
    assign m_axi_araddr  = w_araddr[r_grant];
    assign m_axi_arlen   = w_arlen[r_grant];
    assign m_axi_arsize  = w_arsize[r_grant];
    assign m_axi_arburst = w_arburst[r_grant];
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = ARB_ARCACHE;
    assign m_axi_arprot  = ARB_ARPROT;

    assign s_axi_rid   = {S_COUNT{m_axi_rid}};
    assign s_axi_rdata = {S_COUNT{m_axi_rdata}};
    assign s_axi_rresp = {S_COUNT{m_axi_rresp}};
    assign s_axi_rlast = {S_COUNT{m_axi_rlast}};

    // State register plus grant and round-robin pointer; master 0 leads after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GRANT_W'(S_COUNT - 1);
        end else begin
            r_state <= w_next_state;
            if (w_grant_load) begin
                r_grant <= w_sel_grant;
            end
            if (w_burst_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Next state and handshake steering toward the granted slice only
    always_comb begin
        w_next_state  = r_state;
        w_grant_load  = 1'b0;
        w_burst_done  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_load = 1'b1;
                    w_next_state = ST_ADDR;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid          = s_axi_arvalid[r_grant];
                s_axi_arready[r_grant] = m_axi_arready;
                if (s_axi_arvalid[r_grant] && m_axi_arready) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state = ST_ADDR;
                end
            end
            ST_DATA: begin
                s_axi_rvalid[r_grant] = m_axi_rvalid;
                m_axi_rready          = s_axi_rready[r_grant];
                if (m_axi_rvalid && s_axi_rready[r_grant] && m_axi_rlast) begin
                    w_burst_done = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_ram_rd_arbiter.sv
// Randomized scoreboard bench for axi_ram_rd_arbiter with a behavioural RAM and
// arbitration reference model; honours AXI_RD_ARB_FIXED_PRIO_EN.
module tb_axi_ram_rd_arbiter;

    localparam int S  = 2;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [S*IW-1:0] s_axi_arid = '0;
    logic [S*AW-1:0] s_axi_araddr = '0;
    logic [S*8-1:0]  s_axi_arlen = '0;
    logic [S*3-1:0]  s_axi_arsize = '0;
    logic [S*2-1:0]  s_axi_arburst = '0;
    logic [S-1:0]    s_axi_arvalid = '0;
    logic [S-1:0]    s_axi_arready;
    logic [S*IW-1:0] s_axi_rid;
    logic [S*DW-1:0] s_axi_rdata;
    logic [S*2-1:0]  s_axi_rresp;
    logic [S-1:0]    s_axi_rlast;
    logic [S-1:0]    s_axi_rvalid;
    logic [S-1:0]    s_axi_rready = '0;
    logic [IW-1:0]   m_axi_arid;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arlock;
    logic [3:0]      m_axi_arcache;
    logic [2:0]      m_axi_arprot;
    logic            m_axi_arvalid;
    logic            m_axi_arready = 1'b0;
    logic [IW-1:0]   m_axi_rid = '0;
    logic [DW-1:0]   m_axi_rdata = '0;
    logic [1:0]      m_axi_rresp = '0;
    logic            m_axi_rlast = 1'b0;
    logic            m_axi_rvalid = 1'b0;
    logic            m_axi_rready;

    axi_ram_rd_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } burst_t;

    typedef struct {
        int            master;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // master-side stimulus state
    bit            av     [S];
    logic [AW-1:0] a_addr [S];
    logic [7:0]    a_len  [S];
    logic [IW-1:0] a_id   [S];

    // RAM model and expected-response scoreboard
    burst_t ram_q[$];
    int     ram_beat = 0;
    bit     ram_rv = 1'b0;
    beat_t  exp_q[$];

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
        logic [7:0] bb;
        bb = 8'(b);
        return {a ^ 16'hC3A5, bb, ~bb};
    endfunction

    function automatic int pick(input logic [S-1:0] req, input int last);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        for (int i = 0; i < S; i++) if (req[i]) return i;
`else
        for (int d = 1; d <= S; d++) if (req[(last + d) % S]) return (last + d) % S;
`endif
        return 0;
    endfunction

    // One clock of stimulus: drive at negedge, then record the handshakes that the next posedge takes
    task automatic step(input bit allow_new, input bit do_rst);
        beat_t  b;
        burst_t nb;
        @(negedge clk);
        rst = do_rst;
        for (int k = 0; k < S; k++) begin
            if (!av[k] && allow_new && !do_rst && $urandom_range(0, 3) == 0) begin
                av[k]     = 1'b1;
                a_addr[k] = AW'($urandom);
                a_len[k]  = 8'($urandom_range(0, 7));
                a_id[k]   = IW'($urandom);
            end
            s_axi_arvalid[k]          = av[k] && !do_rst;
            s_axi_araddr[k*AW +: AW]  = a_addr[k];
            s_axi_arlen[k*8 +: 8]     = a_len[k];
            s_axi_arid[k*IW +: IW]    = a_id[k];
            s_axi_arsize[k*3 +: 3]    = 3'd2;
            s_axi_arburst[k*2 +: 2]   = 2'b01;
            s_axi_rready[k]           = !do_rst && ($urandom_range(0, 3) != 0);
        end
        m_axi_arready = !do_rst && ($urandom_range(0, 2) != 0);
        if (!ram_rv && ram_q.size() > 0 && !do_rst) ram_rv = ($urandom_range(0, 3) != 0);
        m_axi_rvalid = ram_rv && !do_rst;
        if (ram_q.size() > 0) begin
            m_axi_rdata = beat_data(ram_q[0].addr, ram_beat);
            m_axi_rid   = ram_q[0].id;
            m_axi_rresp = 2'(ram_beat);
            m_axi_rlast = (ram_beat == int'(ram_q[0].len));
        end else begin
            m_axi_rdata = '0;
            m_axi_rid   = '0;
            m_axi_rresp = 2'b00;
            m_axi_rlast = 1'b0;
        end
        #1;
        if (do_rst) begin
            ram_q.delete();
            exp_q.delete();
            ram_beat = 0;
            ram_rv   = 1'b0;
            for (int k = 0; k < S; k++) av[k] = 1'b0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (s_axi_arvalid[k] && s_axi_arready[k]) begin
                    av[k] = 1'b0;
                    for (int i = 0; i <= int'(a_len[k]); i++) begin
                        b.master = k;
                        b.data   = beat_data(a_addr[k], i);
                        b.id     = a_id[k];
                        b.resp   = 2'(i);
                        b.last   = (i == int'(a_len[k]));
                        exp_q.push_back(b);
                    end
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                nb.addr = m_axi_araddr;
                nb.len  = m_axi_arlen;
                nb.id   = m_axi_arid;
                ram_q.push_back(nb);
            end
            if (m_axi_rvalid && m_axi_rready) begin
                ram_rv = 1'b0;
                if (ram_q.size() > 0 && ram_beat == int'(ram_q[0].len)) begin
                    void'(ram_q.pop_front());
                    ram_beat = 0;
                end else begin
                    ram_beat++;
                end
            end
        end
    endtask

    // Monitor: arbitration reference model, routing checks and R-beat scoreboard
    initial begin
        int phase = 0;   // 0 idle, 1 address, 2 data
        int win = 0;
        int last = S - 1;
        bit prev_rst = 1'b1;
        bit exp_mav;
        bit exp_mrr;
        logic [S-1:0] exp_ard;
        logic [S-1:0] exp_rv;
        beat_t h;
        forever begin
            @(negedge clk);
            #2;
            if (!(rst && !prev_rst)) begin
                exp_mav = 1'b0; exp_mrr = 1'b0; exp_ard = '0; exp_rv = '0;
                if (phase == 1) begin
                    exp_mav      = s_axi_arvalid[win];
                    exp_ard[win] = m_axi_arready;
                end else if (phase == 2) begin
                    exp_rv[win] = m_axi_rvalid;
                    exp_mrr     = s_axi_rready[win];
                end
                checks++;
                if ({s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready} !==
                    {exp_ard, exp_rv, exp_mav, exp_mrr}) begin
                    errors++;
                    $display("FAIL route t=%0t arready/rvalid/m_arvalid/m_rready got=%b %b %b %b want=%b %b %b %b",
                             $time, s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready,
                             exp_ard, exp_rv, exp_mav, exp_mrr);
                end
                if (phase == 1) begin
                    checks++;
                    if ({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} !==
                        {s_axi_arid[win*IW +: IW], s_axi_araddr[win*AW +: AW], s_axi_arlen[win*8 +: 8],
                         s_axi_arsize[win*3 +: 3], s_axi_arburst[win*2 +: 2]}) begin
                        errors++;
                        $display("FAIL ar_payload t=%0t master=%0d got id=%h addr=%h len=%0d want id=%h addr=%h len=%0d",
                                 $time, win, m_axi_arid, m_axi_araddr, m_axi_arlen,
                                 s_axi_arid[win*IW +: IW], s_axi_araddr[win*AW +: AW], s_axi_arlen[win*8 +: 8]);
                    end
                end
                for (int k = 0; k < S; k++) begin
                    if (s_axi_rvalid[k] && s_axi_rready[k]) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL r_beat t=%0t master=%0d got unexpected beat want none", $time, k);
                        end else begin
                            h = exp_q.pop_front();
                            if (h.master != k || s_axi_rdata[k*DW +: DW] !== h.data || s_axi_rid[k*IW +: IW] !== h.id ||
                                s_axi_rresp[k*2 +: 2] !== h.resp || s_axi_rlast[k] !== h.last) begin
                                errors++;
                                $display("FAIL r_beat t=%0t got m=%0d d=%h id=%h resp=%0d last=%b want m=%0d d=%h id=%h resp=%0d last=%b",
                                         $time, k, s_axi_rdata[k*DW +: DW], s_axi_rid[k*IW +: IW],
                                         s_axi_rresp[k*2 +: 2], s_axi_rlast[k], h.master, h.data, h.id, h.resp, h.last);
                            end
                        end
                    end
                end
            end
            if (rst) begin
                phase = 0;
                last  = S - 1;
            end else if (phase == 0) begin
                if (|s_axi_arvalid) begin
                    win   = pick(s_axi_arvalid, last);
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (s_axi_arvalid[win] && m_axi_arready) phase = 2;
            end else begin
                if (m_axi_rvalid && s_axi_rready[win] && m_axi_rlast) begin
                    last  = win;
                    phase = 0;
                end
            end
            prev_rst = rst;
        end
    end

    // Main sequence: reset, random traffic, reset mid-burst, more traffic, drain
    initial begin
        int  n;
        bit  done;
        for (int k = 0; k < S; k++) begin
            av[k] = 1'b0; a_addr[k] = '0; a_len[k] = '0; a_id[k] = '0;
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if ({m_axi_arlock, m_axi_arcache, m_axi_arprot} !== {1'b0, 4'b0011, 3'b000}) begin
            errors++;
            $display("FAIL ar_consts got lock=%b cache=%b prot=%b want 0 0011 000",
                     m_axi_arlock, m_axi_arcache, m_axi_arprot);
        end
        for (int c = 0; c < 4000; c++) step(1'b1, 1'b0);
        n = 0;
        while (!(ram_q.size() > 0 && ram_beat >= 2) && n < 2000) begin
            step(1'b1, 1'b0);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL midburst_wait got no burst past beat 2 within %0d cycles want one", n);
        end
        step(1'b0, 1'b1);
        for (int c = 0; c < 4000; c++) step(1'b1, 1'b0);
        n = 0;
        done = 1'b0;
        while (!done && n < 1000) begin
            step(1'b0, 1'b0);
            n++;
            done = (ram_q.size() == 0) && (exp_q.size() == 0);
            for (int k = 0; k < S; k++) if (av[k]) done = 1'b0;
        end
        step(1'b0, 1'b0);
        checks++;
        if (!done || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d beats still expected want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
